cache_mem_responder: RTL and testbench

Memory-side responder for the cache's valid/ready memory port: the target that the cache's refill and writeback requests talk to. It accepts one word-wide read or write request, holds it for a fixed, parameterised latency, and then completes it with a single-cycle ready pulse, returning read data in that same cycle. It owns a word-addressed storage array and exposes error and statistics outputs. It is used as the backing memory in cache subsystem benches and as the on-chip backing store in small configurations.

---
 rtl/cache_mem_responder.sv | 152 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Word-addressed backing memory behind the cache's valid/ready memory port.
// Optional MEM_RESP_STALL_INJECT_EN adds LFSR-driven random response stalls.
module cache_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_adr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  err_o,
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o
);

    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  stall;
    logic                  enter_resp;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_adr;
    logic                  c_inr;
    logic                  q_inr;

    // With LATENCY=1 the request goes straight to RESP, so use the live inputs
    assign c_we  = (state == IDLE) ? mem_we_i : we_q;
    assign c_adr = (state == IDLE) ? mem_adr_i : adr_q;
    assign c_inr = ({1'b0, c_adr} < DEPTH);
    assign q_inr = ({1'b0, adr_q} < DEPTH);

    assign mem_ready_o = (state == RESP);
    assign enter_resp  = (state_nxt == RESP) && (state != RESP);

`ifdef MEM_RESP_STALL_INJECT_EN
    logic [7:0] lfsr;
    logic [1:0] stall_cnt;

    assign stall = lfsr[0] && (stall_cnt != 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr      <= 8'hA5;
            stall_cnt <= 2'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == IDLE) begin
                stall_cnt <= (LATENCY == 1 && mem_valid_i && stall) ?
                             2'd1 : 2'd0;
            end else if (state == WAIT && cnt <= 4'd1 && stall) begin
                stall_cnt <= stall_cnt + 2'd1;
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

    // WAIT leaves when the counter reaches zero on this edge (cnt <= 1)
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (mem_valid_i) begin
                    cnt_nxt = LAT_LOAD;
                    if (LATENCY == 1) begin
                        if (stall) begin
                            state_nxt = WAIT;
                            cnt_nxt   = 4'd0;
                        end else begin
                            state_nxt = RESP;
                        end
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1 && !stall) state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            mem_rdata_o <= '0;
            err_o       <= 1'b0;
            rd_cnt_o    <= 16'd0;
            wr_cnt_o    <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && mem_valid_i) begin
                we_q    <= mem_we_i;
                adr_q   <= mem_adr_i;
                wdata_q <= mem_wdata_i;
            end
            if (enter_resp) begin
                if (!c_we) begin
                    mem_rdata_o <= c_inr ? mem[c_adr[IW-1:0]] : '0;
                    rd_cnt_o    <= rd_cnt_o + 16'd1;
                end else begin
                    wr_cnt_o <= wr_cnt_o + 16'd1;
                end
                if (!c_inr) err_o <= 1'b1;
            end
        end
    end

    // Storage is not reset; writes commit at the end of RESP
    always_ff @(posedge clk_i) begin
        if (state == RESP && we_q && q_inr) begin
            mem[adr_q[IW-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: one LATENCY=2 and one LATENCY=1
// instance driven by directed vectors; a monitor checks every ready pulse.
module tb_cache_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [1:0]  valid, we, ready, err;
    logic [15:0] adr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];

    cache_mem_responder #(.LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_valid_i(valid[0]), .mem_ready_o(ready[0]),
        .mem_we_i(we[0]), .mem_adr_i(adr[0]),
        .mem_wdata_i(wdata[0]), .mem_rdata_o(rdata[0]),
        .err_o(err[0]), .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0])
    );

    cache_mem_responder #(.LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_valid_i(valid[1]), .mem_ready_o(ready[1]),
        .mem_we_i(we[1]), .mem_adr_i(adr[1]),
        .mem_wdata_i(wdata[1]), .mem_rdata_o(rdata[1]),
        .err_o(err[1]), .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1])
    );

    typedef struct {
        int          d;
        logic        rd;
        logic [31:0] data;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          lat_log[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd [2];
    logic [1:0]  err_m;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected response
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ready[d] === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready dut%0d at cycle %0d", d, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_dut"}, 32'(d), 32'(e.d));
`ifdef MEM_RESP_STALL_INJECT_EN
                    checks++;
                    if (cyc < e.cyc || cyc > e.cyc + 3) begin
                        failures++;
                        $display("FAIL %s_lat: cycle %0d, allowed %0d..%0d",
                                 e.name, cyc, e.cyc, e.cyc + 3);
                    end
                    lat_log.push_back(cyc - e.cyc);
`else
                    chk({e.name, "_lat"}, cyc, e.cyc);
`endif
                    chk({e.name, "_rdata"}, rdata[d], e.data);
                    chk({e.name, "_err"}, 32'(err[d]), 32'(e.err));
                end
            end
        end
    end

    function automatic int lat(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Called at posedge+1; accepted at the next edge
    task automatic req(int d, bit w, logic [15:0] a, logic [31:0] wd,
                       logic [31:0] exp, bit keep, bit scramble, string n);
        exp_t e;
        int   t;
        valid[d] = 1'b1;
        we[d]    = w;
        adr[d]   = a;
        wdata[d] = wd;
        @(posedge clk);
        #1;
        if (a >= 16'h0400) err_m[d] = 1'b1;
        if (!w) last_rd[d] = exp;
        e.d    = d;
        e.rd   = !w;
        e.data = last_rd[d];
        e.err  = err_m[d];
        e.cyc  = cyc + lat(d) - 1;
        e.name = n;
        q.push_back(e);
        if (scramble) begin
            valid[d] = 1'b0;
            adr[d]   = a + 16'd3;
            wdata[d] = ~wd;
            we[d]    = ~w;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ready[d] !== 1'b1 && t < 40);
        if (ready[d] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no ready in %0d cycles", n, t);
        end
        @(posedge clk);
        #1;
        if (!keep) valid[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid    = 2'b00;
        we       = 2'b00;
        err_m    = 2'b00;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p1 [$];
        int nbad;
        for (int d = 0; d < 2; d++) begin
            adr[d]   = 16'd0;
            wdata[d] = 32'd0;
        end
        do_reset();

        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_rdcnt", 32'(rdc[d]), 32'd0);
            chk("rst_wrcnt", 32'(wrc[d]), 32'd0);
        end

        req(0, 1, 16'd5, 32'hDEADBEEF, 32'd0, 0, 0, "wr5");
        chk("wr5_wrcnt", 32'(wrc[0]), 32'd1);
        req(0, 0, 16'd5, 32'd0, 32'hDEADBEEF, 0, 0, "rd5");
        chk("rd5_rdcnt", 32'(rdc[0]), 32'd1);

        req(1, 1, 16'd0, 32'h11, 32'd0, 0, 0, "pre0");
        req(1, 1, 16'd1, 32'h22, 32'd0, 0, 0, "pre1");
        req(1, 0, 16'd0, 32'd0, 32'h11, 1, 0, "bb_rd0");
        req(1, 0, 16'd1, 32'd0, 32'h22, 0, 0, "bb_rd1");
        chk("bb_rdcnt", 32'(rdc[1]), 32'd2);
        chk("bb_wrcnt", 32'(wrc[1]), 32'd2);

        req(0, 1, 16'd0, 32'hCAFE0000, 32'd0, 0, 0, "wr0");
        chk("pre_oor_err", 32'(err[0]), 32'd0);
        req(0, 1, 16'h0400, 32'h12345678, 32'd0, 0, 0, "oor_wr");
        req(0, 0, 16'h0400, 32'd0, 32'd0, 0, 0, "oor_rd");
        req(0, 0, 16'd0, 32'd0, 32'hCAFE0000, 0, 0, "rd0");
        chk("oor_err_sticky", 32'(err[0]), 32'd1);
        chk("oor_wrcnt", 32'(wrc[0]), 32'd3);
        chk("oor_rdcnt", 32'(rdc[0]), 32'd3);

        req(0, 1, 16'd12, 32'h00000012, 32'd0, 0, 0, "wr12");
        req(0, 1, 16'd9, 32'h99990009, 32'd0, 0, 1, "scr_wr9");
        req(0, 0, 16'd9, 32'd0, 32'h99990009, 0, 1, "scr_rd9");
        req(0, 0, 16'd12, 32'd0, 32'h00000012, 0, 0, "rd12");

        req(0, 1, 16'd7, 32'h00000077, 32'd0, 0, 0, "wr7");
        valid[0] = 1'b1;
        we[0]    = 1'b1;
        adr[0]   = 16'd7;
        wdata[0] = 32'h00000BAD;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        chk("midrst_ready", 32'(ready[0]), 32'd0);
        #1 rst_n = 1'b1;
        err_m      = 2'b00;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(posedge clk);
        #1;
        chk("midrst_wrcnt", 32'(wrc[0]), 32'd0);
        chk("midrst_err", 32'(err[0]), 32'd0);
        chk("midrst_rdata", rdata[0], 32'd0);
        req(0, 0, 16'd7, 32'd0, 32'h00000077, 0, 0, "rd7");
        chk("midrst_rdcnt", 32'(rdc[0]), 32'd1);
        chk("midrst_wrcnt2", 32'(wrc[0]), 32'd0);

`ifdef MEM_RESP_STALL_INJECT_EN
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            lat_log.delete();
            for (int i = 0; i < 100; i++) begin
                req(0, 0, 16'd7, 32'd0, 32'h00000077, 0, 0, "stall_rd");
            end
            if (pass == 0) p1 = lat_log;
        end
        nbad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= lat_log.size() || i >= p1.size() || p1[i] != lat_log[i])
                nbad++;
        end
        chk("stall_repeat", 32'(nbad), 32'd0);
`else
        p1   = lat_log;
        nbad = 0;
`endif

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
